rgb_sel_gen: RTL
================

// Module: rgb_sel_gen
// PURPOSE
//  Per-pixel layer arbiter directly upstream of MUX_RGB. Samples the "pixel on" flags of the
//  16 tile generators and the title generator, resolves priority, and registers the one-hot
//  select that drives MUX_RGB.selRGB. Also owns the highlight-blink timer. A highlighted tile
//  is hidden on alternate blink phases so that the layer beneath it shows through.
// PARAMETERS
//  N_TILES       16  number of tile layers; fixed at 16 by the MUX_RGB select width
//  BLINK_FRAMES  15  frames per blink half-period; legal range 1..255
//  FCNT_W        8   width of the frame counter
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous reset, active low
//  pix_tick     in   1   one-clk pixel-rate enable
//  video_on     in   1   high inside the visible area
//  vsync        in   1   vertical sync, active high
//  tile_on      in   16  bit i high = tile i covers the current pixel
//  title_on     in   1   title generator covers the current pixel
//  hl_en        in   1   highlight blinking enabled
//  hl_idx       in   4   index of the highlighted tile
//  sel_rgb      out  17  one-hot select to MUX_RGB; bit 16 = title, bit i = tile i; 0 = black
//  sel_valid    out  1   high when sel_rgb is nonzero
//  blink_phase  out  1   0 = highlight visible, 1 = highlight hidden
// BEHAVIOUR
//  Decided interface: one clock, clk. Reset reset_n is asynchronous and active low.
//  Reset values: sel_rgb=0, sel_valid=0, blink_phase=0, frame counter=0, vsync_q=0.
//  Pixel path
//   - Updates only on a clk edge where pix_tick=1; otherwise holds.
//   - Latency: one pix_tick. Inputs are sampled on the tick edge and the result is visible
//     right after that edge.
//   - Masking: eff_on = tile_on, except that bit hl_idx is forced to 0 when
//     hl_en=1 and blink_phase=1.
//   - Priority: title_on wins first. Otherwise the lowest set index of eff_on wins.
//     If no layer is on, the result is 0.
//   - When video_on=0, sel_rgb=0 regardless of the other inputs.
//   - sel_rgb is always one-hot or zero; no other encoding is legal.
//   - sel_valid is registered in the same edge as sel_rgb and equals |sel_rgb.
//  Blink timer
//   - vsync_q is registered every clk. A frame event is vsync & ~vsync_q (rising edge).
//   - On a frame event with hl_en=1: if fcnt==BLINK_FRAMES-1, then fcnt<=0 and blink_phase
//     toggles; otherwise fcnt<=fcnt+1.
//   - When hl_en=0, fcnt<=0 and blink_phase<=0 synchronously. This makes a new highlight
//     start in the visible phase.
//   - A frame event and pix_tick in the same cycle are independent. That pixel uses the
//     pre-edge blink_phase.
//   - A change of hl_idx takes effect on the next pix_tick. It does not restart the timer.
//  Reset asserted mid-frame clears all state at once. After reset is released, the first
//  pix_tick produces a valid select; no warm-up is required.
// STRUCTURE
//  - rgb_sel_defs.vh: SEL_W=17, TITLE_BIT=16, SEL_NONE=17'b0.
//  - Sub-module rgb_blink_timer: contains vsync edge detect, fcnt and blink_phase; outputs
//    blink_phase.
//  - Top level: the mask, the priority encoder (a for-loop from high index down to low) and
//    the output registers.
// TESTING
//  1. Reset: reset_n=0 in the middle of activity -> sel_rgb=0, sel_valid=0 and blink_phase=0
//     immediately, without waiting for a clk edge.
//  2. Priority: video_on=1, tile_on=16'h0014, title_on=0, tick -> sel_rgb=17'h00004.
//     Then set title_on=1, tick -> sel_rgb=17'h10000.
//  3. Blanking and hold: video_on=0 with tile_on=16'hFFFF, tick -> sel_rgb=0, sel_valid=0.
//     Then change the inputs with pix_tick=0 -> outputs unchanged.
//  4. Blink period: hl_en=1, BLINK_FRAMES=2, apply 4 vsync pulses -> blink_phase toggles
//     after the 2nd and 4th rising edges. A level held high for several clks counts once.
//  5. Masking: hl_idx=3, tile_on=16'h0018, blink_phase=1, tick -> sel_rgb=17'h00010
//     (tile 4 shows through). With blink_phase=0, tick -> 17'h00008.
//  6. Disable: drop hl_en while blink_phase=1 -> next clk gives blink_phase=0 and fcnt=0.
//     Re-enable -> the first toggle needs a full BLINK_FRAMES frame events.

Source files
------------

// File: rtl/rgb_sel_gen_pkg.sv
// Shared constants and helpers for the RGB layer-select arbiter.
// Select is one-hot across 16 tiles plus the title; all-zero means black.
package rgb_sel_gen_pkg;

  localparam int unsigned N_TILES_DEF = 16;
  localparam int unsigned SEL_W       = 17;
  localparam int unsigned TITLE_BIT   = 16;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_NONE = 17'b0;
  localparam sel_t SEL_ONE  = 17'h00001;

  function automatic sel_t sel_onehot(input int idx);
    sel_onehot = SEL_ONE << idx;
  endfunction

endpackage

// File: rtl/rgb_sel_gen_if.sv
// Pixel-side bundle between the layer generators and the RGB select arbiter.
interface rgb_sel_gen_if;
  import rgb_sel_gen_pkg::*;

  logic        pix_tick;
  logic        video_on;
  logic        vsync;
  logic [15:0] tile_on;
  logic        title_on;
  logic        hl_en;
  logic [3:0]  hl_idx;
  sel_t        sel_rgb;
  logic        sel_valid;
  logic        blink_phase;

  modport master (
    output pix_tick, video_on, vsync, tile_on, title_on, hl_en, hl_idx,
    input  sel_rgb, sel_valid, blink_phase
  );

  modport slave (
    input  pix_tick, video_on, vsync, tile_on, title_on, hl_en, hl_idx,
    output sel_rgb, sel_valid, blink_phase
  );
endinterface

// File: rtl/rgb_sel_gen_blink_timer.sv
// Highlight blink timer: counts vsync rising edges and toggles the blink phase
// every BLINK_FRAMES frames while highlighting is enabled.
module rgb_blink_timer #(
  parameter int unsigned BLINK_FRAMES = 15,
  parameter int unsigned FCNT_W       = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_vsync,
  input  logic i_hl_en,
  output logic o_blink_phase
);

  localparam logic [FCNT_W-1:0] LP_LAST = FCNT_W'(BLINK_FRAMES - 1);
  localparam logic [FCNT_W-1:0] LP_ONE  = FCNT_W'(1);

  logic              r_vsync_q;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_blink_phase;
  logic              w_frame_evt;

  assign w_frame_evt   = i_vsync & ~r_vsync_q;
  assign o_blink_phase = r_blink_phase;

  // Disabling the highlight parks the timer so a new highlight starts visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync_q     <= 1'b0;
      r_fcnt        <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_vsync_q <= i_vsync;
      if (!i_hl_en) begin
        r_fcnt        <= '0;
        r_blink_phase <= 1'b0;
      end else if (w_frame_evt) begin
        if (r_fcnt == LP_LAST) begin
          r_fcnt        <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_fcnt <= r_fcnt + LP_ONE;
        end
      end else begin
        r_fcnt        <= r_fcnt;
        r_blink_phase <= r_blink_phase;
      end
    end
  end

endmodule

// File: rtl/rgb_sel_gen.sv
// Per-pixel layer arbiter feeding MUX_RGB: masks the blinking highlight,
// resolves title/tile priority and registers a one-hot select on each pix_tick.
module rgb_sel_gen
  import rgb_sel_gen_pkg::*;
#(
  parameter int unsigned N_TILES      = N_TILES_DEF,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter int unsigned FCNT_W       = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  rgb_sel_gen_if.slave  bus
);

  logic              w_blink_phase;
  logic [N_TILES-1:0] w_eff_on;
  sel_t              w_sel;
  sel_t              r_sel_rgb;
  logic              r_sel_valid;

  rgb_blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES),
    .FCNT_W       (FCNT_W)
  ) u_blink (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_vsync       (bus.vsync),
    .i_hl_en       (bus.hl_en),
    .o_blink_phase (w_blink_phase)
  );

  // Mask the hidden highlight, then scan high-to-low so the lowest set tile wins.
  always_comb begin
    w_eff_on = bus.tile_on;
    if (bus.hl_en && w_blink_phase) begin
      w_eff_on[bus.hl_idx] = 1'b0;
    end else begin
      w_eff_on = bus.tile_on;
    end

    w_sel = SEL_NONE;
    for (int i = N_TILES - 1; i >= 0; i--) begin
      if (w_eff_on[i]) begin
        w_sel = sel_onehot(i);
      end else begin
        w_sel = w_sel;
      end
    end

    if (bus.title_on) begin
      w_sel = sel_onehot(TITLE_BIT);
    end else begin
      w_sel = w_sel;
    end

    if (!bus.video_on) begin
      w_sel = SEL_NONE;
    end else begin
      w_sel = w_sel;
    end
  end

  // Output registers advance only on the pixel-rate enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_rgb   <= SEL_NONE;
      r_sel_valid <= 1'b0;
    end else if (bus.pix_tick) begin
      r_sel_rgb   <= w_sel;
      r_sel_valid <= (w_sel != SEL_NONE);
    end else begin
      r_sel_rgb   <= r_sel_rgb;
      r_sel_valid <= r_sel_valid;
    end
  end

  assign bus.sel_rgb     = r_sel_rgb;
  assign bus.sel_valid   = r_sel_valid;
  assign bus.blink_phase = w_blink_phase;

endmodule
